// File: rtl/pipe_mux.sv
// pipe_mux: registered N-to-1 word selector with a two-entry skid buffer.
// The main register drives the outputs directly; the skid register catches
// a word accepted while downstream stalls, so in_ready can be a pure
// function of state and never depends combinationally on out_ready.
module pipe_mux #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_sel_err,
  output logic                    out_valid,
  input  logic                    out_ready
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t state_reg;
  state_t state_next;

  logic [WIDTH-1:0] main_data_reg;
  logic             main_err_reg;
  logic [WIDTH-1:0] skid_data_reg;
  logic             skid_err_reg;

  logic [WIDTH-1:0] chan [NUM_IN];
  logic [WIDTH-1:0] sel_word;
  logic             sel_err;

  logic accept;
  logic xfer;
  logic load_main;
  logic load_skid;
  logic skid_to_main;

  // Split the flat input bus into one word per channel.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_IN; gi++) begin : g_chan
      assign chan[gi] = in_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Select the addressed channel; an out-of-range select yields zero plus an error flag.
  always_comb begin
    sel_word = '0;
    sel_err  = 1'b1;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        sel_word = chan[k];
        sel_err  = 1'b0;
      end
    end
  end

  // Handshake flags are decoded purely from state.
  assign out_valid   = (state_reg != EMPTY);
  assign in_ready    = (state_reg != TWO);
  assign out_data    = main_data_reg;
  assign out_sel_err = main_err_reg;

  assign accept = in_valid && in_ready;
  assign xfer   = out_valid && out_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and datapath steering decisions.
  always_comb begin
    state_next   = state_reg;
    load_main    = 1'b0;
    load_skid    = 1'b0;
    skid_to_main = 1'b0;
    case (state_reg)
      EMPTY: begin
        if (accept) begin
          load_main  = 1'b1;
          state_next = ONE;
        end
      end
      ONE: begin
        if (accept && xfer) begin
          load_main = 1'b1;
        end else if (accept) begin
          load_skid  = 1'b1;
          state_next = TWO;
        end else if (xfer) begin
          state_next = EMPTY;
        end
      end
      TWO: begin
        if (xfer) begin
          skid_to_main = 1'b1;
          state_next   = ONE;
        end
      end
      default: begin
        state_next = EMPTY;
      end
    endcase
  end

  // Main and skid storage; registers keep their last value when not loaded.
  always_ff @(posedge clk) begin
    if (reset) begin
      main_data_reg <= '0;
      main_err_reg  <= 1'b0;
      skid_data_reg <= '0;
      skid_err_reg  <= 1'b0;
    end else begin
      if (load_main) begin
        main_data_reg <= sel_word;
        main_err_reg  <= sel_err;
      end else if (skid_to_main) begin
        main_data_reg <= skid_data_reg;
        main_err_reg  <= skid_err_reg;
      end
      if (load_skid) begin
        skid_data_reg <= sel_word;
        skid_err_reg  <= sel_err;
      end
    end
  end

endmodule

// File: tb/tb_pipe_mux.sv
// tb_pipe_mux: directed and randomized checks of pipe_mux against a
// two-deep FIFO reference model (one instance with 4 inputs, one with 3).
module tb_pipe_mux;

  logic         clk;
  logic         reset;

  logic [127:0] in_data_a;
  logic [1:0]   sel_a;
  logic         in_valid_a;
  logic         in_ready_a;
  logic [31:0]  out_data_a;
  logic         out_sel_err_a;
  logic         out_valid_a;
  logic         out_ready_a;

  logic [95:0]  in_data_b;
  logic [1:0]   sel_b;
  logic         in_valid_b;
  logic         in_ready_b;
  logic [31:0]  out_data_b;
  logic         out_sel_err_b;
  logic         out_valid_b;
  logic         out_ready_b;

  int n_checks;
  int n_fail;

  // Reference model: each DUT behaves as a FIFO of capacity 2 holding {err, data}.
  logic [32:0] mq_a[$];
  logic [32:0] mq_b[$];

  pipe_mux #(.WIDTH(32), .NUM_IN(4), .SEL_W(2)) dut_a (
    .clk(clk), .reset(reset), .in_data(in_data_a), .sel(sel_a),
    .in_valid(in_valid_a), .in_ready(in_ready_a), .out_data(out_data_a),
    .out_sel_err(out_sel_err_a), .out_valid(out_valid_a), .out_ready(out_ready_a)
  );

  pipe_mux #(.WIDTH(32), .NUM_IN(3), .SEL_W(2)) dut_b (
    .clk(clk), .reset(reset), .in_data(in_data_b), .sel(sel_b),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .out_data(out_data_b),
    .out_sel_err(out_sel_err_b), .out_valid(out_valid_b), .out_ready(out_ready_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [32:0] ref_a(input logic [127:0] d, input logic [1:0] s);
    logic [127:0] t;
    t = d >> (int'(s) * 32);
    return {1'b0, t[31:0]};
  endfunction

  function automatic logic [32:0] ref_b(input logic [95:0] d, input logic [1:0] s);
    logic [95:0] t;
    if (int'(s) >= 3) return {1'b1, 32'h0};
    t = d >> (int'(s) * 32);
    return {1'b0, t[31:0]};
  endfunction

  // Advance one clock edge, updating the reference model with what the edge does.
  task automatic tick();
    bit acc, xf;
    @(posedge clk);
    if (reset) begin
      mq_a.delete();
      mq_b.delete();
    end else begin
      acc = in_valid_a && (mq_a.size() < 2);
      xf  = (mq_a.size() > 0) && out_ready_a;
      if (xf) void'(mq_a.pop_front());
      if (acc) mq_a.push_back(ref_a(in_data_a, sel_a));
      acc = in_valid_b && (mq_b.size() < 2);
      xf  = (mq_b.size() > 0) && out_ready_b;
      if (xf) void'(mq_b.pop_front());
      if (acc) mq_b.push_back(ref_b(in_data_b, sel_b));
    end
    #1;
  endtask

  task automatic idle_inputs();
    in_valid_a = 1'b0; out_ready_a = 1'b0; sel_a = 2'd0;
    in_valid_b = 1'b0; out_ready_b = 1'b0; sel_b = 2'd0;
    in_data_a  = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    in_data_b  = {32'h33333333, 32'h22222222, 32'h11111111};
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    in_valid_a = 1'b1;
    in_valid_b = 1'b1;
    tick();
    tick();
    n_checks++;
    if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_flags_a: valid=%b ready=%b required valid=0 ready=1", out_valid_a, in_ready_a);
    end
    n_checks++;
    if (out_data_a !== 32'h0 || out_sel_err_a !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_data_a: data=%h err=%b required 00000000/0", out_data_a, out_sel_err_a);
    end
    n_checks++;
    if (out_valid_b !== 1'b0 || in_ready_b !== 1'b1 || out_data_b !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_b: valid=%b ready=%b data=%h required 0/1/00000000", out_valid_b, in_ready_b, out_data_b);
    end
    reset = 1'b0;
    in_valid_a = 1'b0;
    in_valid_b = 1'b0;
    tick();
    n_checks++;
    if (out_valid_a !== 1'b0 || out_valid_b !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ignores_accept: valid_a=%b valid_b=%b required 0/0", out_valid_a, out_valid_b);
    end
    $display("test_reset done");
  endtask

  task automatic test_passthrough();
    idle_inputs();
    sel_a = 2'd2; in_valid_a = 1'b1; out_ready_a = 1'b1;
    tick();
    in_valid_a = 1'b0;
    n_checks++;
    if (out_valid_a !== 1'b1 || out_data_a !== 32'h33333333 || out_sel_err_a !== 1'b0) begin
      n_fail++;
      $display("FAIL passthrough_word: valid=%b data=%h err=%b required 1/33333333/0", out_valid_a, out_data_a, out_sel_err_a);
    end
    tick();
    n_checks++;
    if (out_valid_a !== 1'b0) begin
      n_fail++;
      $display("FAIL passthrough_drain: valid=%b required 0", out_valid_a);
    end
    $display("test_passthrough done");
  endtask

  task automatic test_backpressure();
    idle_inputs();
    in_valid_a = 1'b1; sel_a = 2'd0;
    tick();
    sel_a = 2'd1;
    tick();
    in_valid_a = 1'b0;
    n_checks++;
    if (in_ready_a !== 1'b0 || out_valid_a !== 1'b1 || out_data_a !== 32'h11111111) begin
      n_fail++;
      $display("FAIL bp_full: ready=%b valid=%b data=%h required 0/1/11111111", in_ready_a, out_valid_a, out_data_a);
    end
    // Wiggle sel/data without valid while stalled: outputs must hold.
    sel_a = 2'd3;
    in_data_a = 128'hdeadbeef_cafef00d_01234567_89abcdef;
    tick();
    n_checks++;
    if (out_data_a !== 32'h11111111 || out_sel_err_a !== 1'b0 || in_ready_a !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_hold: data=%h err=%b ready=%b required 11111111/0/0", out_data_a, out_sel_err_a, in_ready_a);
    end
    out_ready_a = 1'b1;
    tick();
    n_checks++;
    if (out_valid_a !== 1'b1 || out_data_a !== 32'h22222222 || in_ready_a !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_second: valid=%b data=%h ready=%b required 1/22222222/1", out_valid_a, out_data_a, in_ready_a);
    end
    tick();
    n_checks++;
    if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_drain: valid=%b ready=%b required 0/1", out_valid_a, in_ready_a);
    end
    $display("test_backpressure done");
  endtask

  task automatic test_streaming();
    logic [31:0] words [4];
    idle_inputs();
    words[0] = 32'h11111111; words[1] = 32'h22222222;
    words[2] = 32'h33333333; words[3] = 32'h44444444;
    out_ready_a = 1'b1;
    in_valid_a = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sel_a = 2'(i % 4);
      tick();
      n_checks++;
      if (out_valid_a !== 1'b1 || out_data_a !== words[i % 4] || in_ready_a !== 1'b1) begin
        n_fail++;
        $display("FAIL stream_%0d: valid=%b data=%h ready=%b required 1/%h/1", i, out_valid_a, out_data_a, in_ready_a, words[i % 4]);
      end
    end
    in_valid_a = 1'b0;
    tick();
    n_checks++;
    if (out_valid_a !== 1'b0) begin
      n_fail++;
      $display("FAIL stream_drain: valid=%b required 0", out_valid_a);
    end
    $display("test_streaming done");
  endtask

  task automatic test_out_of_range();
    idle_inputs();
    sel_b = 2'd3; in_valid_b = 1'b1; out_ready_b = 1'b0;
    tick();
    n_checks++;
    if (out_valid_b !== 1'b1 || out_data_b !== 32'h0 || out_sel_err_b !== 1'b1) begin
      n_fail++;
      $display("FAIL oor_word: valid=%b data=%h err=%b required 1/00000000/1", out_valid_b, out_data_b, out_sel_err_b);
    end
    sel_b = 2'd1; out_ready_b = 1'b1;
    tick();
    in_valid_b = 1'b0;
    n_checks++;
    if (out_valid_b !== 1'b1 || out_data_b !== 32'h22222222 || out_sel_err_b !== 1'b0) begin
      n_fail++;
      $display("FAIL oor_next: valid=%b data=%h err=%b required 1/22222222/0", out_valid_b, out_data_b, out_sel_err_b);
    end
    tick();
    n_checks++;
    if (out_valid_b !== 1'b0) begin
      n_fail++;
      $display("FAIL oor_drain: valid=%b required 0", out_valid_b);
    end
    $display("test_out_of_range done");
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    in_valid_a = 1'b1; sel_a = 2'd2;
    tick();
    sel_a = 2'd3;
    tick();
    n_checks++;
    if (in_ready_a !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_full: ready=%b required 0", in_ready_a);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    in_valid_a = 1'b0;
    n_checks++;
    if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1 || out_data_a !== 32'h0 || out_sel_err_a !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_cleared: valid=%b ready=%b data=%h err=%b required 0/1/00000000/0", out_valid_a, in_ready_a, out_data_a, out_sel_err_a);
    end
    out_ready_a = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (out_valid_a !== 1'b0) begin
        n_fail++;
        $display("FAIL rmid_ghost_%0d: valid=%b required 0", i, out_valid_a);
      end
    end
    $display("test_reset_mid done");
  endtask

  task automatic test_simultaneous();
    int old_xfers;
    idle_inputs();
    old_xfers = 0;
    in_valid_a = 1'b1; sel_a = 2'd0;
    tick();
    out_ready_a = 1'b1; sel_a = 2'd3;
    if (out_valid_a && out_ready_a && out_data_a == 32'h11111111) old_xfers++;
    tick();
    in_valid_a = 1'b0;
    n_checks++;
    if (out_valid_a !== 1'b1 || in_ready_a !== 1'b1 || out_data_a !== 32'h44444444) begin
      n_fail++;
      $display("FAIL simul_one: valid=%b ready=%b data=%h required 1/1/44444444", out_valid_a, in_ready_a, out_data_a);
    end
    for (int i = 0; i < 3; i++) begin
      if (out_valid_a && out_ready_a && out_data_a == 32'h11111111) old_xfers++;
      tick();
    end
    n_checks++;
    if (old_xfers != 1 || out_valid_a !== 1'b0) begin
      n_fail++;
      $display("FAIL simul_once: old word transfers=%0d valid=%b required 1/0", old_xfers, out_valid_a);
    end
    $display("test_simultaneous done");
  endtask

  task automatic test_random();
    idle_inputs();
    for (int i = 0; i < 400; i++) begin
      in_valid_a  = ($urandom_range(0, 3) != 0);
      out_ready_a = ($urandom_range(0, 2) != 0);
      sel_a       = 2'($urandom_range(0, 3));
      in_data_a   = {$urandom, $urandom, $urandom, $urandom};
      in_valid_b  = $urandom_range(0, 1) == 1;
      out_ready_b = $urandom_range(0, 1) == 1;
      sel_b       = 2'($urandom_range(0, 3));
      in_data_b   = {$urandom, $urandom, $urandom};
      n_checks++;
      if (out_valid_a !== (mq_a.size() > 0) || in_ready_a !== (mq_a.size() < 2)) begin
        n_fail++;
        $display("FAIL rand_flags_a cycle %0d: valid=%b ready=%b required %b/%b", i, out_valid_a, in_ready_a, mq_a.size() > 0, mq_a.size() < 2);
      end
      if (mq_a.size() > 0) begin
        n_checks++;
        if ({out_sel_err_a, out_data_a} !== mq_a[0]) begin
          n_fail++;
          $display("FAIL rand_data_a cycle %0d: got %h required %h", i, {out_sel_err_a, out_data_a}, mq_a[0]);
        end
      end
      n_checks++;
      if (out_valid_b !== (mq_b.size() > 0) || in_ready_b !== (mq_b.size() < 2)) begin
        n_fail++;
        $display("FAIL rand_flags_b cycle %0d: valid=%b ready=%b required %b/%b", i, out_valid_b, in_ready_b, mq_b.size() > 0, mq_b.size() < 2);
      end
      if (mq_b.size() > 0) begin
        n_checks++;
        if ({out_sel_err_b, out_data_b} !== mq_b[0]) begin
          n_fail++;
          $display("FAIL rand_data_b cycle %0d: got %h required %h", i, {out_sel_err_b, out_data_b}, mq_b[0]);
        end
      end
      tick();
    end
    $display("test_random done");
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    idle_inputs();
    test_reset();
    test_passthrough();
    test_backpressure();
    test_streaming();
    test_out_of_range();
    test_reset_mid();
    test_simultaneous();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
